// File: rtl/shower_ctrl_if.sv
// Bus bundle for shower_ctrl: config handshake, shower class in/out, FIFO readout, statistics.
interface shower_ctrl_if #(
  parameter int TH_W  = 10,
  parameter int BX_W  = 12,
  parameter int CNT_W = 16
);
  logic              cfg_wr;
  logic [1:0]        cfg_sel;
  logic [TH_W-1:0]   cfg_data;
  logic              cfg_commit;
  logic              cfg_ack;
  logic              cfg_err;
  logic [TH_W-1:0]   th_loose;
  logic [TH_W-1:0]   th_nominal;
  logic [TH_W-1:0]   th_tight;
  logic [1:0]        shower_int;
  logic              bx0;
  logic [1:0]        shower_out;
  logic              rd_en;
  logic [BX_W+1:0]   rd_data;
  logic              rd_empty;
  logic [CNT_W-1:0]  cnt_acc;
  logic [CNT_W-1:0]  cnt_sup;
  logic [CNT_W-1:0]  cnt_ovf;

  modport master (
    output cfg_wr, cfg_sel, cfg_data, cfg_commit, shower_int, bx0, rd_en,
    input  cfg_ack, cfg_err, th_loose, th_nominal, th_tight, shower_out,
           rd_data, rd_empty, cnt_acc, cnt_sup, cnt_ovf
  );

  modport slave (
    input  cfg_wr, cfg_sel, cfg_data, cfg_commit, shower_int, bx0, rd_en,
    output cfg_ack, cfg_err, th_loose, th_nominal, th_tight, shower_out,
           rd_data, rd_empty, cnt_acc, cnt_sup, cnt_ovf
  );
endinterface

// File: rtl/shower_ctrl.sv
// Anode shower controller: shadow/commit thresholds, holdoff qualification, readout FIFO, counters.
// Define SHOWER_BX_STAMP_EN to stamp FIFO entries with the bunch-crossing number.
module shower_ctrl #(
  parameter int              TH_W     = 10,
  parameter int              BX_W     = 12,
  parameter int              BX_MAX   = 3563,
  parameter int              HOLD_W   = 4,
  parameter int              FIFO_AW  = 2,
  parameter int              CNT_W    = 16,
  parameter logic [TH_W-1:0] TH_L_DEF = 10'd30,
  parameter logic [TH_W-1:0] TH_N_DEF = 10'd60,
  parameter logic [TH_W-1:0] TH_T_DEF = 10'd100
) (
  input logic          clk,
  input logic          rst_n,
  shower_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_AW;
`ifdef SHOWER_BX_STAMP_EN
  localparam int EW = BX_W + 2;
`else
  localparam int EW = 2;
`endif
  localparam logic [HOLD_W-1:0] HOLD_DEF = HOLD_W'(4);
  localparam logic [0:0]        S_IDLE   = 1'b0;
  localparam logic [0:0]        S_HOLD   = 1'b1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // ---------------- configuration ----------------
  logic [TH_W-1:0]   sh_l_q, sh_n_q, sh_t_q;
  logic [TH_W-1:0]   th_l_q, th_n_q, th_t_q;
  logic [HOLD_W-1:0] sh_h_q, hold_q;
  logic              ack_q, err_q;
  logic              commit_ok;

  // Ordering is judged on the shadows as they stand this cycle, before any same-cycle write.
  assign commit_ok = (sh_l_q <= sh_n_q) && (sh_n_q <= sh_t_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_l_q <= TH_L_DEF;
      sh_n_q <= TH_N_DEF;
      sh_t_q <= TH_T_DEF;
      sh_h_q <= HOLD_DEF;
      th_l_q <= TH_L_DEF;
      th_n_q <= TH_N_DEF;
      th_t_q <= TH_T_DEF;
      hold_q <= HOLD_DEF;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      ack_q <= bus.cfg_commit && commit_ok;
      err_q <= bus.cfg_commit && !commit_ok;
      if (bus.cfg_commit && commit_ok) begin
        th_l_q <= sh_l_q;
        th_n_q <= sh_n_q;
        th_t_q <= sh_t_q;
        hold_q <= sh_h_q;
      end
      if (bus.cfg_wr) begin
        case (bus.cfg_sel)
          2'd0:    sh_l_q <= bus.cfg_data;
          2'd1:    sh_n_q <= bus.cfg_data;
          2'd2:    sh_t_q <= bus.cfg_data;
          default: sh_h_q <= bus.cfg_data[HOLD_W-1:0];
        endcase
      end
    end
  end

  assign bus.cfg_ack    = ack_q;
  assign bus.cfg_err    = err_q;
  assign bus.th_loose   = th_l_q;
  assign bus.th_nominal = th_n_q;
  assign bus.th_tight   = th_t_q;

  // ---------------- holdoff FSM ----------------
  logic [0:0]        state_q, state_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [1:0]        sout_q, sout_d;
  logic              accept, suppress;

  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    sout_d   = 2'd0;
    accept   = 1'b0;
    suppress = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.shower_int != 2'd0) begin
          accept = 1'b1;
          sout_d = bus.shower_int;
          if (hold_q != '0) begin
            state_d = S_HOLD;
            hcnt_d  = hold_q;
          end
        end
      end
      default: begin
        suppress = (bus.shower_int != 2'd0);
        hcnt_d   = hcnt_q - HOLD_W'(1);
        if (hcnt_q == HOLD_W'(1)) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      sout_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      sout_q  <= sout_d;
    end
  end

  assign bus.shower_out = sout_q;

  // ---------------- BX stamp ----------------
  logic [EW-1:0] push_data;

`ifdef SHOWER_BX_STAMP_EN
  logic [BX_W-1:0] bx_q, bx_d;

  always_comb begin
    if (bus.bx0)                        bx_d = '0;
    else if (bx_q == BX_W'(BX_MAX))     bx_d = '0;
    else                                bx_d = bx_q + BX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bx_q <= '0;
    else        bx_q <= bx_d;
  end

  // Stamp with the BX in which shower_out is presented to the trigger path.
  assign push_data = {bx_d, bus.shower_int};
`else
  logic unused_bx;
  assign unused_bx = bus.bx0 ^ (BX_MAX == 0);
  assign push_data = bus.shower_int;
`endif

  // ---------------- readout FIFO ----------------
  logic [EW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q, rp_d;
  logic [FIFO_AW:0]   fcnt_q, fcnt_d, fcnt_pop;
  logic [EW-1:0]      rd_q, rd_d;
  logic               pop, full, push_ok, drop;

  always_comb begin
    pop      = bus.rd_en && (fcnt_q != '0);
    full     = (fcnt_q == (FIFO_AW+1)'(DEPTH));
    push_ok  = accept && (!full || pop);
    drop     = accept && !push_ok;
    fcnt_pop = pop ? fcnt_q - (FIFO_AW+1)'(1) : fcnt_q;
    fcnt_d   = push_ok ? fcnt_pop + (FIFO_AW+1)'(1) : fcnt_pop;
    rp_d     = pop ? rp_q + FIFO_AW'(1) : rp_q;
    // Head register tracks the entry at the read pointer after this edge; bypass on push into empty.
    rd_d     = (push_ok && (fcnt_pop == '0)) ? push_data : mem_q[rp_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
      rd_q   <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + FIFO_AW'(1);
      rp_q   <= rp_d;
      fcnt_q <= fcnt_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.rd_empty = (fcnt_q == '0);
`ifdef SHOWER_BX_STAMP_EN
  assign bus.rd_data  = rd_q;
`else
  assign bus.rd_data  = {{BX_W{1'b0}}, rd_q};
`endif

  // ---------------- statistics ----------------
  logic [CNT_W-1:0] acc_q, sup_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sup_q <= '0;
      ovf_q <= '0;
    end else begin
      acc_q <= sat_inc(acc_q, accept);
      sup_q <= sat_inc(sup_q, suppress);
      ovf_q <= sat_inc(ovf_q, drop);
    end
  end

  assign bus.cnt_acc = acc_q;
  assign bus.cnt_sup = sup_q;
  assign bus.cnt_ovf = ovf_q;

endmodule

// File: tb/tb_shower_ctrl.sv
// Bench for shower_ctrl: config handshake, holdoff table, FIFO scoreboard, saturation, async reset.
module tb_shower_ctrl;
  localparam int TH_W   = 10;
  localparam int BX_W   = 12;
  localparam int CNT_W  = 6;
  localparam int BX_MAX = 3563;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shower_ctrl_if #(.TH_W(TH_W), .BX_W(BX_W), .CNT_W(CNT_W)) bus();

  shower_ctrl #(.TH_W(TH_W), .BX_W(BX_W), .BX_MAX(BX_MAX), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int mbx   = 0;
  int e_acc = 0;
  int e_sup = 0;
  int e_ovf = 0;
  logic [BX_W+1:0] sbq[$];

  typedef struct {
    logic [1:0] sin;
    logic [1:0] out;
    logic       sup;
  } hvec_t;
  hvec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    int nxt;
    nxt = bus.bx0 ? 0 : ((mbx == BX_MAX) ? 0 : mbx + 1);
    @(posedge clk);
    if (rst_n) mbx = nxt;
    else       mbx = 0;
    #1;
  endtask

  function automatic int inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic logic [BX_W+1:0] ent(input logic [1:0] c);
    logic [31:0] b;
    b = mbx;
`ifdef SHOWER_BX_STAMP_EN
    return {b[BX_W-1:0], c};
`else
    b = 0;
    return {b[BX_W-1:0], c};
`endif
  endfunction

  // Model of one accepted shower: FIFO occupancy is the scoreboard depth.
  task automatic accept_exp(input logic [1:0] c);
    e_acc = inc(e_acc);
    if (sbq.size() < 4) sbq.push_back(ent(c));
    else                e_ovf = inc(e_ovf);
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, "_acc"}, bus.cnt_acc, e_acc);
    chk({nm, "_sup"}, bus.cnt_sup, e_sup);
    chk({nm, "_ovf"}, bus.cnt_ovf, e_ovf);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [TH_W-1:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_sel = sel; bus.cfg_data = d;
    step();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic commit(input string nm, input logic ok);
    bus.cfg_commit = 1'b1;
    step();
    bus.cfg_commit = 1'b0;
    chk({nm, "_ack"}, bus.cfg_ack, ok);
    chk({nm, "_err"}, bus.cfg_err, !ok);
  endtask

  task automatic chk_th(input string nm, input int l, input int n, input int t);
    chk({nm, "_loose"}, bus.th_loose, l);
    chk({nm, "_nom"},   bus.th_nominal, n);
    chk({nm, "_tight"}, bus.th_tight, t);
  endtask

  task automatic drain();
    logic [BX_W+1:0] e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("fifo_nonempty", bus.rd_empty, 0);
      chk("fifo_head", bus.rd_data, e);
      bus.rd_en = 1'b1;
      step();
      bus.rd_en = 1'b0;
    end
    chk("fifo_empty", bus.rd_empty, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'd2, 2'd2, 1'b0};
    tbl[1] = '{2'd2, 2'd0, 1'b1};
    tbl[2] = '{2'd2, 2'd0, 1'b1};
    tbl[3] = '{2'd2, 2'd0, 1'b1};
    tbl[4] = '{2'd2, 2'd2, 1'b0};
    tbl[5] = '{2'd0, 2'd0, 1'b0};
    tbl[6] = '{2'd0, 2'd0, 1'b0};
    tbl[7] = '{2'd0, 2'd0, 1'b0};
    tbl[8] = '{2'd3, 2'd3, 1'b0};

    bus.cfg_wr = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = '0; bus.cfg_commit = 1'b0;
    bus.shower_int = 2'd0; bus.bx0 = 1'b0; bus.rd_en = 1'b0;

    // Reset state
    repeat (3) step();
    chk_th("rst", 30, 60, 100);
    chk("rst_empty", bus.rd_empty, 1);
    chk("rst_out", bus.shower_out, 0);
    chk("rst_ack", bus.cfg_ack, 0);
    chk("rst_err", bus.cfg_err, 0);
    chk_cnt("rst");
    @(negedge clk) rst_n = 1'b1;
    step();

    // Shadows equal live after reset
    commit("c0", 1'b1);
    chk_th("c0", 30, 60, 100);

    // Good commit: all three land together with ack
    wr(2'd0, 10'd40); wr(2'd1, 10'd80); wr(2'd2, 10'd120);
    chk_th("shadow_only", 30, 60, 100);
    commit("c1", 1'b1);
    chk_th("c1", 40, 80, 120);
    step();
    chk("c1_ack_pulse", bus.cfg_ack, 0);

    // Ordering violation
    wr(2'd2, 10'd50);
    commit("c2", 1'b0);
    chk_th("c2", 40, 80, 120);

    // Write and commit in one cycle: commit sees old (bad) tight, write lands after
    bus.cfg_wr = 1'b1; bus.cfg_sel = 2'd2; bus.cfg_data = 10'd130; bus.cfg_commit = 1'b1;
    step();
    bus.cfg_wr = 1'b0;
    chk("c3_err", bus.cfg_err, 1);
    chk("c3_tight", bus.th_tight, 120);
    step();
    bus.cfg_commit = 1'b0;
    chk("c4_ack", bus.cfg_ack, 1);
    chk("c4_tight", bus.th_tight, 130);

    // Holdoff = 3, table-driven
    wr(2'd3, 10'd3);
    commit("hold3", 1'b1);
    for (int i = 0; i < 9; i++) begin
      bus.shower_int = tbl[i].sin;
      step();
      chk($sformatf("hold_out%0d", i), bus.shower_out, tbl[i].out);
      if (tbl[i].out != 2'd0) accept_exp(tbl[i].out);
      if (tbl[i].sup) e_sup = inc(e_sup);
      chk_cnt($sformatf("hold%0d", i));
    end
    bus.shower_int = 2'd0;
    drain();

    // Five spaced showers into a depth-4 FIFO: last one dropped
    for (int k = 0; k < 5; k++) begin
      bus.shower_int = 2'(k % 3 + 1);
      step();
      chk($sformatf("ovf_out%0d", k), bus.shower_out, k % 3 + 1);
      accept_exp(2'(k % 3 + 1));
      bus.shower_int = 2'd0;
      repeat (3) step();
    end
    chk_cnt("ovf");
    chk("ovf_one", bus.cnt_ovf, 1);

    // Full FIFO with simultaneous pop and push: push succeeds
    chk("full_head", bus.rd_data, sbq[0]);
    bus.shower_int = 2'd2; bus.rd_en = 1'b1;
    step();
    bus.shower_int = 2'd0; bus.rd_en = 1'b0;
    void'(sbq.pop_front());
    accept_exp(2'd2);
    chk("full_pp_out", bus.shower_out, 2);
    chk_cnt("full_pp");
    repeat (3) step();
    drain();

    // Holdoff = 0: accept every cycle, counters saturate
    wr(2'd3, 10'd0);
    commit("hold0", 1'b1);
    for (int i = 0; i < 70; i++) begin
      bus.shower_int = 2'd1;
      step();
      chk("h0_out", bus.shower_out, 1);
      accept_exp(2'd1);
    end
    bus.shower_int = 2'd0;
    step();
    chk("h0_idle", bus.shower_out, 0);
    chk_cnt("sat");
    chk("sat_acc", bus.cnt_acc, CMAX);
    chk("sat_ovf", bus.cnt_ovf, CMAX);
    drain();

    // Async reset mid-HOLD with a commit pending
    wr(2'd3, 10'd5);
    commit("hold5", 1'b1);
    wr(2'd0, 10'd41); wr(2'd1, 10'd81); wr(2'd2, 10'd121);
    bus.shower_int = 2'd1;
    step();
    accept_exp(2'd1);
    bus.shower_int = 2'd0;
    step();
    bus.cfg_commit = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    sbq.delete(); e_acc = 0; e_sup = 0; e_ovf = 0; mbx = 0;
    chk_th("arst", 30, 60, 100);
    chk("arst_out", bus.shower_out, 0);
    chk("arst_empty", bus.rd_empty, 1);
    chk_cnt("arst");
    step();
    chk_th("arst_commit", 30, 60, 100);
    chk("arst_ack", bus.cfg_ack, 0);
    bus.cfg_commit = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    commit("arst_c", 1'b1);
    chk_th("arst_c", 30, 60, 100);

    // Default holdoff 4 restored
    for (int i = 0; i < 6; i++) begin
      bus.shower_int = 2'd2;
      step();
      chk($sformatf("h4_out%0d", i), bus.shower_out, (i == 0 || i == 5) ? 2 : 0);
      if (i == 0 || i == 5) accept_exp(2'd2);
      else                  e_sup = inc(e_sup);
    end
    bus.shower_int = 2'd0;
    chk_cnt("h4");
    repeat (5) step();
    drain();

`ifdef SHOWER_BX_STAMP_EN
    bus.bx0 = 1'b1; step(); bus.bx0 = 1'b0;
    repeat (9) step();
    bus.shower_int = 2'd1; step(); bus.shower_int = 2'd0;
    accept_exp(2'd1);
    chk("bx_stamp10", bus.rd_data[BX_W+1:2], 10);
    drain();
    bus.bx0 = 1'b1; step(); bus.bx0 = 1'b0;
    repeat (BX_MAX) step();
    bus.shower_int = 2'd3; step(); bus.shower_int = 2'd0;
    accept_exp(2'd3);
    chk("bx_wrap", bus.rd_data[BX_W+1:2], 0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
